// File: rtl/arima_seq_ctrl.sv
// arima_seq_ctrl: run sequencer for the ARIMA datapath.
// A run is: clear the datapath, ingest a history window through the sample
// handshake, seed the integrator, then alternate STEP/WAIT until the
// programmed number of forecasts has been handed to the consumer.
module arima_seq_ctrl #(
  parameter int N     = 32,
  parameter int CNT_W = 16,
  parameter int d_max = 10,
  parameter int p_max = 10,
  parameter int q_max = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_hist,
  input  logic [CNT_W-1:0] n_pred,
  input  logic [N-1:0]     d_order,
  input  logic [N-1:0]     p_order,
  input  logic [N-1:0]     q_order,
  input  logic             smp_valid,
  output logic             smp_ready,
  input  logic [N-1:0]     smp_data,
  output logic [N-1:0]     dp_data_in,
  input  logic [N-1:0]     dp_data_out,
  input  logic             dp_overflow,
  output logic [1:0]       c_diff,
  output logic [1:0]       c_ar,
  output logic [1:0]       c_ma,
  output logic [1:0]       c_inte,
  output logic             sel_inte_in,
  output logic             fc_valid,
  input  logic             fc_ready,
  output logic [N-1:0]     fc_data,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             ovf_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_WARM, S_SEED, S_STEP, S_WAIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    SHIFT = 2'b01,
    CLEAR = 2'b10,
    INIT  = 2'b11
  } code_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hist_cnt, hist_nxt;
  logic [CNT_W-1:0] pred_cnt, pred_nxt;
  logic [CNT_W-1:0] n_hist_r, n_pred_r;
  logic [N-1:0]     last_smp;
  code_t            diff_r, ar_r, ma_r, inte_r;
  code_t            diff_nxt, ar_nxt, ma_nxt, inte_nxt;
  logic             sel_nxt;
  logic             cfg_bad, start_ok, smp_hs, warm_shift;

  // Orders compare unsigned on the full word, so "negative" orders are rejected.
  assign cfg_bad  = (d_order > N'(d_max)) || (p_order > N'(p_max)) ||
                    (q_order > N'(q_max)) || (N'(n_hist) <= d_order) ||
                    (n_pred == '0);
  assign start_ok = start && (state == S_IDLE) && !cfg_bad;
  assign smp_hs   = smp_valid && smp_ready;
  // SHIFT has to land on the accepted beat itself, so WARM bypasses the code registers.
  assign warm_shift = (state == S_WARM) && smp_hs;

  assign c_diff     = warm_shift ? SHIFT : diff_r;
  assign c_ar       = warm_shift ? SHIFT : ar_r;
  assign c_ma       = warm_shift ? SHIFT : ma_r;
  assign c_inte     = warm_shift ? SHIFT : inte_r;
  assign dp_data_in = (state == S_WARM) ? smp_data : last_smp;

  // Next-state and counter update logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    hist_nxt  = hist_cnt;
    pred_nxt  = pred_cnt;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_CLR;
      S_CLR: begin
        hist_nxt  = '0;
        state_nxt = S_WARM;
      end
      S_WARM: if (smp_hs) begin
        hist_nxt = hist_cnt + CNT_ONE;
        if (hist_nxt == n_hist_r) state_nxt = S_SEED;
      end
      S_SEED: begin
        pred_nxt  = '0;
        state_nxt = S_STEP;
      end
      S_STEP: state_nxt = S_WAIT;
      S_WAIT: if (fc_ready) begin
        pred_nxt  = pred_cnt + CNT_ONE;
        state_nxt = (pred_nxt == n_pred_r) ? S_DONE : S_STEP;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage codes for the state being entered; registered below so they are glitch-free.
  always_comb begin
    diff_nxt = HOLD;
    ar_nxt   = HOLD;
    ma_nxt   = HOLD;
    inte_nxt = HOLD;
    sel_nxt  = 1'b1;
    case (state_nxt)
      S_CLR: begin
        diff_nxt = CLEAR;
        ar_nxt   = CLEAR;
        ma_nxt   = CLEAR;
        inte_nxt = CLEAR;
      end
      S_SEED: begin
        diff_nxt = INIT;
        inte_nxt = INIT;
      end
      S_STEP: begin
        ar_nxt   = SHIFT;
        ma_nxt   = SHIFT;
        inte_nxt = SHIFT;
        sel_nxt  = 1'b0;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Counters, captured run parameters, last accepted sample and forecast word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_cnt <= '0;
      pred_cnt <= '0;
      n_hist_r <= '0;
      n_pred_r <= '0;
      last_smp <= '0;
      fc_data  <= '0;
    end else begin
      hist_cnt <= hist_nxt;
      pred_cnt <= pred_nxt;
      if (start_ok) begin
        n_hist_r <= n_hist;
        n_pred_r <= n_pred;
      end
      if (warm_shift)        last_smp <= smp_data;
      if (state == S_STEP)   fc_data  <= dp_data_out;
    end
  end

  // Registered control and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r      <= HOLD;
      ar_r        <= HOLD;
      ma_r        <= HOLD;
      inte_r      <= HOLD;
      sel_inte_in <= 1'b1;
      smp_ready   <= 1'b0;
      fc_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      diff_r      <= diff_nxt;
      ar_r        <= ar_nxt;
      ma_r        <= ma_nxt;
      inte_r      <= inte_nxt;
      sel_inte_in <= sel_nxt;
      smp_ready   <= (state_nxt == S_WARM);
      fc_valid    <= (state_nxt == S_WAIT);
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
      cfg_err     <= start && (state == S_IDLE) && cfg_bad;
      if (start_ok)                ovf_err <= 1'b0;
      else if (busy && dp_overflow) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arima_seq_ctrl.sv
// Bench for arima_seq_ctrl. A monitor on the falling edge checks every cycle
// against a run-level model: the expected run is a token sequence
// (CLEAR, n_hist SHIFT beats, INIT, n_pred STEP/accept pairs, DONE) built
// from the captured counts, plus simple expectations for the status flags.
module tb_arima_seq_ctrl;
  localparam int N     = 32;
  localparam int CNT_W = 16;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam byte TK_C = 1, TK_S = 2, TK_I = 3, TK_T = 4, TK_F = 5, TK_D = 6;

  logic             clk = 1'b0;
  logic             rst_n, start, smp_valid, smp_ready, dp_overflow;
  logic [CNT_W-1:0] n_hist, n_pred;
  logic [N-1:0]     d_order, p_order, q_order, smp_data, dp_data_in, dp_data_out, fc_data;
  logic [1:0]       c_diff, c_ar, c_ma, c_inte;
  logic             sel_inte_in, fc_valid, fc_ready, busy, done, cfg_err, ovf_err;

  int checks = 0;
  int failures = 0;

  arima_seq_ctrl #(.N(N), .CNT_W(CNT_W), .d_max(10), .p_max(10), .q_max(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_hist(n_hist), .n_pred(n_pred),
    .d_order(d_order), .p_order(p_order), .q_order(q_order),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .dp_data_in(dp_data_in), .dp_data_out(dp_data_out), .dp_overflow(dp_overflow),
    .c_diff(c_diff), .c_ar(c_ar), .c_ma(c_ma), .c_inte(c_inte),
    .sel_inte_in(sel_inte_in), .fc_valid(fc_valid), .fc_ready(fc_ready), .fc_data(fc_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Background stimulus: sample/forecast data and the two handshakes.
  bit stall = 0;
  int tick = 0;
  int fc_cnt = 0;
  initial begin
    smp_valid = 1'b0; fc_ready = 1'b0; smp_data = '0; dp_data_out = '0;
    forever begin
      @(posedge clk); #1;
      tick++;
      smp_data    = 32'h5A00_0000 + 32'(tick);
      dp_data_out = 32'hC300_0000 ^ (32'(tick) * 32'h0001_9E37);
      if (stall) begin
        smp_valid = ~smp_valid;
        if (fc_valid) begin
          fc_cnt++;
          fc_ready = (fc_cnt > 4);
        end else begin
          fc_cnt = 0;
          fc_ready = 1'b0;
        end
      end else begin
        smp_valid = 1'b1;
        fc_ready  = 1'b1;
        fc_cnt    = 0;
      end
    end
  end

  // Model state.
  bit          mon_en = 0;
  bit          run_active, warm_m, fcv_m, cfg_m, ovf_m, done_m, prev_stall, hs, legal, acc;
  int          nh_m, np_m, n_shift, n_step, n_fc, n_stall, run_cyc, bad;
  int          last_shift, last_step, last_fc, last_stall, last_done_cyc;
  logic [31:0] last_smp_m, prev_fc, exp_val;
  logic [7:0]  codes;
  byte         exp_tok[$], obs_tok[$];
  logic [31:0] exp_fc[$];

  // Single compare process.
  always @(negedge clk) begin
    if (!mon_en) begin
      run_active = 0; warm_m = 0; fcv_m = 0; cfg_m = 0; ovf_m = 0; done_m = 0;
      prev_stall = 0; last_smp_m = '0; run_cyc = 0;
      exp_tok.delete(); obs_tok.delete(); exp_fc.delete();
    end else begin
      if (run_active) run_cyc++;
      check("busy", busy, run_active);
      check("smp_ready", smp_ready, warm_m);
      check("fc_valid", fc_valid, fcv_m);
      check("cfg_err", cfg_err, cfg_m);
      check("ovf_err", ovf_err, ovf_m);
      check("done", done, done_m);
      done_m = 0;

      codes = {c_diff, c_ar, c_ma, c_inte};
      hs = smp_ready && smp_valid;
      if (hs) begin
        check("warm_codes", {codes, sel_inte_in}, {8'b0101_0101, 1'b1});
        check("dp_in_warm", dp_data_in, smp_data);
        obs_tok.push_back(TK_S);
        last_smp_m = smp_data;
        n_shift++;
        if (n_shift == nh_m) warm_m = 0;
      end else if (c_diff == 2'b10) begin
        check("clr_codes", codes, 8'b1010_1010);
        obs_tok.push_back(TK_C);
        warm_m = 1;
      end else if (c_diff == 2'b11) begin
        check("seed_codes", codes, 8'b1100_0011);
        obs_tok.push_back(TK_I);
      end else if (c_ar == SHIFT) begin
        check("step_codes", {codes, sel_inte_in}, {8'b0001_0101, 1'b0});
        check("dp_in_step", dp_data_in, last_smp_m);
        obs_tok.push_back(TK_T);
        exp_fc.push_back(dp_data_out);
        n_step++;
        fcv_m = 1;
      end else begin
        check("hold_codes", codes, 8'h00);
      end

      if (fc_valid) begin
        if (prev_stall) begin
          check("fc_stable", fc_data, prev_fc);
          n_stall++;
        end
        if (fc_ready) begin
          check("fc_pending", exp_fc.size() != 0, 1'b1);
          exp_val = (exp_fc.size() != 0) ? exp_fc.pop_front() : 32'hDEAD_BEEF;
          check("fc_data", fc_data, exp_val);
          obs_tok.push_back(TK_F);
          n_fc++;
          fcv_m = 0;
          if (n_fc == np_m) done_m = 1;
        end
        prev_stall = !fc_ready;
        prev_fc = fc_data;
      end else begin
        prev_stall = 0;
      end

      if (done) begin
        obs_tok.push_back(TK_D);
        check("seq_len", obs_tok.size(), exp_tok.size());
        bad = -1;
        for (int i = 0; i < obs_tok.size() && i < exp_tok.size(); i++)
          if (obs_tok[i] != exp_tok[i] && bad < 0) bad = i;
        check("seq_first_bad_index", bad, -1);
        last_shift = n_shift; last_step = n_step; last_fc = n_fc;
        last_stall = n_stall; last_done_cyc = run_cyc;
      end

      legal = (d_order <= 32'd10) && (p_order <= 32'd10) && (q_order <= 32'd10) &&
              ({16'd0, n_hist} > d_order) && (n_pred != 0);
      acc   = start && !run_active && legal;
      cfg_m = start && !run_active && !legal;
      if (run_active && dp_overflow) ovf_m = 1;
      if (done) run_active = 0;
      if (acc) begin
        ovf_m = 0; run_active = 1; run_cyc = 0;
        nh_m = int'(n_hist); np_m = int'(n_pred);
        n_shift = 0; n_step = 0; n_fc = 0; n_stall = 0;
        warm_m = 0; fcv_m = 0; prev_stall = 0;
        obs_tok.delete(); exp_fc.delete(); exp_tok.delete();
        exp_tok.push_back(TK_C);
        for (int i = 0; i < nh_m; i++) exp_tok.push_back(TK_S);
        exp_tok.push_back(TK_I);
        for (int i = 0; i < np_m; i++) begin
          exp_tok.push_back(TK_T);
          exp_tok.push_back(TK_F);
        end
        exp_tok.push_back(TK_D);
      end
    end
  end

  task automatic pulse_start(input int nh, input int np, input logic [31:0] d,
                             input logic [31:0] p, input logic [31:0] q);
    n_hist = CNT_W'(nh); n_pred = CNT_W'(np);
    d_order = d; p_order = p; q_order = q;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("run_done_seen", seen, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic bad_cfg(input int nh, input int np, input logic [31:0] d,
                         input logic [31:0] p, input logic [31:0] q);
    pulse_start(nh, np, d, p, q);
    check("cfg_err_pulse", cfg_err, 1'b1);
    check("cfg_stays_idle", busy, 1'b0);
    @(posedge clk); #1;
    check("cfg_err_one_cycle", cfg_err, 1'b0);
    check("cfg_no_clear", c_diff, 2'b00);
  endtask

  initial begin
    int steps;
    bit seen;
    rst_n = 1'b0; start = 1'b0; n_hist = '0; n_pred = '0;
    d_order = '0; p_order = '0; q_order = '0; dp_overflow = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_codes", {c_diff, c_ar, c_ma, c_inte}, 8'h00);
    check("rst_sel_inte_in", sel_inte_in, 1'b1);
    check("rst_status", {smp_ready, fc_valid, busy, done, cfg_err, ovf_err}, 6'b0);
    check("rst_fc_data", fc_data, 32'h0);
    check("rst_dp_data_in", dp_data_in, 32'h0);
    rst_n = 1'b1; mon_en = 1;
    @(posedge clk); #1;

    // Nominal: CLR + 5 beats + SEED + 3 x (STEP, WAIT) + DONE -> done 14 cycles after the start edge.
    pulse_start(5, 3, 1, 2, 1);
    wait_done(60);
    check("nom_done_cycle", last_done_cyc, 14);
    check("nom_shift_beats", last_shift, 5);
    check("nom_steps", last_step, 3);
    check("nom_forecasts", last_fc, 3);

    // Stalled handshakes: each forecast is held for 4 non-ready cycles.
    stall = 1;
    pulse_start(5, 3, 1, 2, 1);
    wait_done(200);
    stall = 0;
    check("stall_shift_beats", last_shift, 5);
    check("stall_forecasts", last_fc, 3);
    check("stall_hold_cycles", last_stall, 12);

    // Illegal configurations, including an all-ones (negative) order.
    bad_cfg(5, 3, 1, 11, 1);
    bad_cfg(1, 3, 1, 0, 0);
    bad_cfg(5, 0, 1, 2, 1);
    bad_cfg(40, 3, 32'hFFFF_FFFF, 0, 0);

    // Minimum window n_hist = d+1 with a single forecast: 1 + 2 + 1 + 2 + 1 = 7.
    pulse_start(2, 1, 1, 0, 0);
    wait_done(40);
    check("min_done_cycle", last_done_cyc, 7);
    check("min_forecasts", last_fc, 1);

    // Overflow during the second STEP is sticky and cleared by the next accepted start.
    pulse_start(5, 3, 1, 2, 1);
    steps = 0;
    for (int i = 0; i < 60 && steps < 2; i++) begin
      @(posedge clk); #1;
      if (c_ar == SHIFT && !smp_ready) steps++;
    end
    check("ovf_step2_reached", steps, 2);
    dp_overflow = 1'b1;
    @(posedge clk); #1;
    dp_overflow = 1'b0;
    wait_done(60);
    check("ovf_sticky_after_done", ovf_err, 1'b1);
    check("ovf_run_completed", last_fc, 3);
    pulse_start(5, 1, 1, 2, 1);
    check("ovf_cleared_by_start", ovf_err, 1'b0);
    wait_done(60);

    // Start pulse mid-forecast is ignored.
    pulse_start(5, 3, 1, 2, 1);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (fc_valid) seen = 1;
    end
    check("ign_fc_reached", seen, 1'b1);
    pulse_start(7, 1, 0, 0, 0);
    check("ign_still_busy", busy, 1'b1);
    wait_done(60);
    check("ign_shift_beats", last_shift, 5);
    check("ign_forecasts", last_fc, 3);
    repeat (3) @(posedge clk); #1;
    check("ign_no_restart", busy, 1'b0);

    // Asynchronous reset in the middle of WARM, then a clean run.
    pulse_start(5, 3, 1, 2, 1);
    repeat (2) @(posedge clk); #1;
    check("rst_mid_in_warm", smp_ready, 1'b1);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_codes", {c_diff, c_ar, c_ma, c_inte}, 8'h00);
    check("rst_mid_status", {smp_ready, fc_valid, busy, done}, 4'b0);
    check("rst_mid_sel", sel_inte_in, 1'b1);
    check("rst_mid_dp_in", dp_data_in, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1;
    @(posedge clk); #1;
    pulse_start(5, 3, 1, 2, 1);
    wait_done(60);
    check("post_rst_done_cycle", last_done_cyc, 14);
    check("post_rst_shift_beats", last_shift, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
